// File: rtl/gf2_pkg.sv
// Shared types and constants for the GF(2) polynomial divider.
// Build option: define GF2DIV_EARLY_TERM_EN for data-dependent latency.
package gf2_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/gf2_lead_deg.sv
// Leading-term degree of a GF(2) polynomial: index of the highest set bit.
// deg_o is only meaningful when nonzero_o is 1.
module gf2_lead_deg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEG_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] val_i,
  output logic [DEG_W-1:0] deg_o,
  output logic             nonzero_o
);

  // Ascending scan so the highest set bit wins.
  always_comb begin
    deg_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (val_i[i]) begin
        deg_o = DEG_W'(i);
      end
    end
  end

  assign nonzero_o = |val_i;

endmodule

// File: rtl/gf2_poly_div_seq.sv
// Sequential GF(2) polynomial long division, one reduction step per BUSY cycle.
// Build option: GF2DIV_EARLY_TERM_EN exits BUSY as soon as no step remains;
// otherwise BUSY always lasts WIDTH cycles.
module gf2_poly_div_seq
  import gf2_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned DEG_W = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [DEG_W-1:0] deg_rem, deg_dsr, shift;
  logic             rem_nz, dsr_nz, can_step;
  logic [WIDTH-1:0] r_step, q_step;

`ifdef GF2DIV_EARLY_TERM_EN
`else
  logic [DEG_W-1:0] cnt_q, cnt_d;
  logic             last_cycle;
  assign last_cycle = (cnt_q == DEG_W'(WIDTH - 1));
`endif

  gf2_lead_deg #(
    .WIDTH (WIDTH),
    .DEG_W (DEG_W)
  ) u_deg_rem (
    .val_i     (r_q),
    .deg_o     (deg_rem),
    .nonzero_o (rem_nz)
  );

  gf2_lead_deg #(
    .WIDTH (WIDTH),
    .DEG_W (DEG_W)
  ) u_deg_dsr (
    .val_i     (dsr_q),
    .deg_o     (deg_dsr),
    .nonzero_o (dsr_nz)
  );

  // One long-division step: cancel the leading term of r when it can be reduced.
  assign can_step = rem_nz && dsr_nz && (deg_rem >= deg_dsr);
  assign shift    = deg_rem - deg_dsr;
  assign r_step   = can_step ? (r_q ^ (dsr_q << shift)) : r_q;
  assign q_step   = can_step ? (q_q ^ (WIDTH'(1) << shift)) : q_q;

  always_comb begin
    state_d = state_q;
    dsr_d   = dsr_q;
    q_d     = q_q;
    r_d     = r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef GF2DIV_EARLY_TERM_EN
`else
    cnt_d   = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          dsr_d = divisor;
          q_d   = '0;
          r_d   = dividend;
          if (divisor == '0) begin
            state_d = StDone;
            quot_d  = '0;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = StBusy;
`ifdef GF2DIV_EARLY_TERM_EN
`else
            cnt_d   = '0;
`endif
          end
        end
      end
      StBusy: begin
        q_d = q_step;
        r_d = r_step;
`ifdef GF2DIV_EARLY_TERM_EN
        if (!can_step) begin
          state_d = StDone;
          quot_d  = q_q;
          rem_d   = r_q;
          dbz_d   = 1'b0;
        end
`else
        cnt_d = cnt_q + 1'b1;
        if (last_cycle) begin
          state_d = StDone;
          quot_d  = q_step;
          rem_d   = r_step;
          dbz_d   = 1'b0;
        end
`endif
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      dsr_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef GF2DIV_EARLY_TERM_EN
`else
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dsr_q   <= dsr_d;
      q_q     <= q_d;
      r_q     <= r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef GF2DIV_EARLY_TERM_EN
`else
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/gf2_poly_div_seq.md
GF2_POLY_DIV_SEQ -- requirements
Module: gf2_poly_div_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 2..32.
REQ-002 The block SHALL have derived localparam DEG_W = $clog2(WIDTH)+1, the degree field width.
REQ-003 The block SHALL have these ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands.
- dividend  in  WIDTH  GF(2) polynomial, bit i = coefficient of x^i.
- divisor  in  WIDTH  GF(2) polynomial.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  WIDTH  result quotient.
- remainder  out  WIDTH  result remainder.
- div_by_zero  out  1  divisor was zero.

Function
REQ-004 The block SHALL compute quotient q and remainder r over GF(2), with dividend = q*divisor XOR r, and r = 0 or deg(r) < deg(divisor).
REQ-005 The FSM SHALL have states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-006 On an accept (IDLE and in_valid at a clock edge), the block SHALL latch both operands, set q=0 and r=dividend, and go to BUSY.
REQ-007 On the accept edge with divisor==0, the block SHALL go directly to DONE with quotient=0, remainder=dividend and div_by_zero=1.
REQ-008 Each BUSY cycle SHALL perform one step, with s = deg(r) - deg(divisor):
- if r != 0 and s >= 0: r ^= divisor<<s and q ^= 1<<s;
- otherwise: no change.
REQ-009 deg() SHALL be a true priority encode (deg(x^0)=0); it is meaningful only for nonzero values.
REQ-010 In DONE, quotient, remainder and div_by_zero SHALL hold stable until out_ready=1; the edge with out_valid&out_ready SHALL return the FSM to IDLE.
REQ-011 Throughput: a new accept SHALL occur no earlier than the cycle after the DONE handshake; overlapping operations are not supported.
REQ-012 in_valid while in BUSY or DONE SHALL be ignored, and operand changes in those states SHALL have no effect.
REQ-013 The result registers SHALL update only on DONE entry, so that outputs outside DONE retain the last result.
REQ-014 If divisor==1, quotient SHALL equal dividend and remainder SHALL be 0.

Reset
REQ-015 reset=1 at a clock edge SHALL force IDLE and clear quotient, remainder, div_by_zero, out_valid and the internal q and r, from any state including mid-BUSY.
REQ-016 After reset the block SHALL drive in_ready=1 in the first cycle following the reset edge.
REQ-017 An operation aborted by reset SHALL produce no out_valid.

Configuration
REQ-018 When the macro GF2DIV_EARLY_TERM_EN is defined, BUSY SHALL exit to DONE on the first cycle in which r==0 or deg(r)<deg(divisor).
- Busy cycles then equal popcount(q)+1.
REQ-019 When GF2DIV_EARLY_TERM_EN is undefined, BUSY SHALL last exactly WIDTH cycles, giving fixed latency.
- DONE is entered on the WIDTH-th BUSY edge.
- Results are identical to the early-termination build.

Structure
REQ-020 A shared package gf2_pkg SHALL hold the FSM state enum (IDLE, BUSY, DONE) and the default WIDTH constant.
REQ-021 One sub-module, gf2_lead_deg (parameter WIDTH; in WIDTH bits; out deg DEG_W bits, plus a nonzero flag), SHALL provide the priority encoder and be instanced twice: for r and for the latched divisor.

Verification
REQ-022 Test: 0x53 / 0x0B -> quotient=0x09, remainder=0x00, div_by_zero=0; with early termination, 3 BUSY cycles; without it, 8.
REQ-023 Test: 0xFF / 0x03 -> quotient=0x55, remainder=0x00; with early termination, 5 BUSY cycles.
REQ-024 Test: 0x05 / 0x09 -> quotient=0x00, remainder=0x05; with early termination, 1 BUSY cycle.
REQ-025 Test: 0x3C / 0x00 -> DONE on the cycle after accept, with quotient=0x00, remainder=0x3C, div_by_zero=1.
REQ-026 Test: 0x53 / 0x0B with out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored, IDLE one cycle after out_ready=1.
REQ-027 Test: reset asserted on the 2nd BUSY cycle -> next cycle IDLE, all outputs 0, no out_valid; a following 0x53 / 0x0B op completes correctly.
